// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with bus handshake timeout and illegal-op detection.
// Define CTRL_BRANCH_EN to decode BEQ and drive pc_src from the EXEC-latched zero flag.
module multicycle_control #(
  parameter int ALU_OP_W    = 3,
  parameter int BUS_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                bus_ack,
  output logic                ir_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                i_or_r,
  output logic                bus_req,
  output logic                bus_write,
  output logic                load,
  output logic                reg_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                illegal,
  output logic                bus_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_ILL} kind_e;

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic [ALU_OP_W-1:0] alu_q, alu_d;
  logic                sel_r_q, sel_r_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                timeout;

  assign timeout = (cnt_q == CNT_W'(BUS_TIMEOUT));

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    kind_d  = kind_q;
    alu_d   = alu_q;
    sel_r_d = sel_r_q;
    if (state_q == S_DECODE) begin
      kind_d  = K_ILL;
      alu_d   = '0;
      sel_r_d = 1'b0;
      case (op)
        6'b000000: begin
          case (funct)
            6'b100000: begin kind_d = K_ALU; alu_d = ALU_OP_W'(1); sel_r_d = 1'b1; end
            6'b100010: begin kind_d = K_ALU; alu_d = ALU_OP_W'(2); sel_r_d = 1'b1; end
            6'b100100: begin kind_d = K_ALU; alu_d = ALU_OP_W'(3); sel_r_d = 1'b1; end
            6'b100101: begin kind_d = K_ALU; alu_d = ALU_OP_W'(4); sel_r_d = 1'b1; end
            default: ;
          endcase
        end
        6'b001000: begin kind_d = K_ALU; alu_d = ALU_OP_W'(1); end
        6'b100011: begin kind_d = K_LW;  alu_d = ALU_OP_W'(1); end
        6'b101011: begin kind_d = K_SW;  alu_d = ALU_OP_W'(1); end
`ifdef CTRL_BRANCH_EN
        6'b000100: begin kind_d = K_BEQ; alu_d = ALU_OP_W'(2); sel_r_d = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    abort_d = abort_q;
    case (state_q)
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        abort_d = 1'b0;
        state_d = (kind_d == K_ILL) ? S_WB : S_EXEC;
      end
      S_EXEC:   state_d = (kind_q == K_LW || kind_q == K_SW) ? S_MEM : S_WB;
      S_MEM: begin
        // An ack arriving in the timeout cycle still completes the access cleanly.
        if (bus_ack) begin
          state_d = S_WB;
        end else if (timeout) begin
          state_d = S_WB;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      kind_q  <= K_ALU;
      alu_q   <= '0;
      sel_r_q <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      alu_q   <= alu_d;
      sel_r_q <= sel_r_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

`ifdef CTRL_BRANCH_EN
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      zero_q <= zero;
    end
  end

  assign pc_src = (state_q == S_WB) && (kind_q == K_BEQ) && zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign pc_src      = 1'b0;
`endif

  // Outputs decode only registered state, so reset clears them asynchronously.
  always_comb begin
    ir_write  = (state_q == S_DECODE);
    alu_op    = '0;
    i_or_r    = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op = alu_q;
      i_or_r = sel_r_q;
    end
    bus_req   = (state_q == S_MEM);
    bus_write = (state_q == S_MEM) && (kind_q == K_SW);
    load      = (state_q == S_MEM || state_q == S_WB) && (kind_q == K_LW);
    reg_write = (state_q == S_WB) && (kind_q == K_ALU || kind_q == K_LW) && !abort_q;
    pc_write  = (state_q == S_WB);
    illegal   = (state_q == S_WB) && (kind_q == K_ILL);
    bus_err   = (state_q == S_WB) && abort_q;
    busy      = (state_q != S_FETCH);
  end

endmodule
